control_rw_flow: RTL and testbench



---
 rtl/control_rw_flow.sv | 126 ++++++++++++
 tb/tb_control_rw_flow.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_rw_flow.sv
// Read/write command sequencer between the serial front end and the memory array.
// Optional transfer watchdog: define TIMEOUT_EN to abort XFER states after TIMEOUT_CYCLES.
module control_rw_flow #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic Clk,
    input  logic Reset,
    input  logic RW,
    input  logic ValidCmd,
    input  logic Active,
    input  logic Mode,
    input  logic TransferDone,
    output logic AccessMem,
    output logic RWMem,
    output logic SampleData,
    output logic TransferData,
    output logic Busy
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ACCESS,
        RD_SAMPLE,
        RD_XFER,
        WR_XFER,
        WR_ACCESS
    } state_t;

    state_t state;
    state_t state_next;
    logic   mode_q;
    logic   timeout;

    wire cmd_accept = (state == IDLE) && ValidCmd && Active;

    // Direction is carried by the path the FSM takes; only Mode is needed later.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mode_q <= 1'b0;
        end else if (cmd_accept) begin
            mode_q <= Mode;
        end
    end

`ifdef TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] xfer_cnt;
    wire in_xfer = (state == RD_XFER) || (state == WR_XFER);

    // Counts cycles already spent in the current XFER stay; zero on entry.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            xfer_cnt <= '0;
        end else if (in_xfer && (state_next == state)) begin
            xfer_cnt <= xfer_cnt + CNT_W'(1);
        end else begin
            xfer_cnt <= '0;
        end
    end

    assign timeout = in_xfer && (xfer_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: next state defaults to the current state first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (cmd_accept) begin
                    if (!RW)       state_next = RD_ACCESS;
                    else if (Mode) state_next = WR_XFER;
                    else           state_next = WR_ACCESS;
                end
            end
            RD_ACCESS: state_next = RD_SAMPLE;
            RD_SAMPLE: state_next = RD_XFER;
            RD_XFER: begin
                if (!mode_q || TransferDone || timeout) state_next = IDLE;
            end
            WR_XFER: begin
                if (TransferDone)  state_next = WR_ACCESS;
                else if (timeout)  state_next = IDLE;
            end
            WR_ACCESS: state_next = IDLE;
            default:   state_next = IDLE;
        endcase

        // Loss of Active overrides every other exit condition.
        if ((state != IDLE) && !Active) state_next = IDLE;
    end

    // Moore outputs: pure decode of the registered state.
    always_comb begin
        AccessMem    = 1'b0;
        RWMem        = 1'b0;
        SampleData   = 1'b0;
        TransferData = 1'b0;
        Busy         = (state != IDLE);
        unique case (state)
            RD_ACCESS: AccessMem = 1'b1;
            RD_SAMPLE: SampleData = 1'b1;
            RD_XFER,
            WR_XFER:   TransferData = 1'b1;
            WR_ACCESS: begin
                AccessMem = 1'b1;
                RWMem     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_rw_flow.sv
// Self-checking bench for control_rw_flow: directed scenarios plus randomized
// transactions compared against a per-transaction expected output trace.
module tb_control_rw_flow;

    localparam int TIMEOUT_CYCLES = 64;

    // Output vector order: {AccessMem, RWMem, SampleData, TransferData, Busy}
    localparam logic [4:0] V_IDLE  = 5'b00000;
    localparam logic [4:0] V_RD_AM = 5'b10001;
    localparam logic [4:0] V_SD    = 5'b00101;
    localparam logic [4:0] V_TD    = 5'b00011;
    localparam logic [4:0] V_WR_AM = 5'b11001;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic RW = 1'b0;
    logic ValidCmd = 1'b0;
    logic Active = 1'b0;
    logic Mode = 1'b0;
    logic TransferDone = 1'b0;
    logic AccessMem, RWMem, SampleData, TransferData, Busy;
    logic [4:0] outs;

    int n_assert = 0;
    int n_fail   = 0;

    logic [4:0] exp_q[$];
    bit         done_q[$];

    assign outs = {AccessMem, RWMem, SampleData, TransferData, Busy};

    control_rw_flow #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .RW(RW),
        .ValidCmd(ValidCmd),
        .Active(Active),
        .Mode(Mode),
        .TransferDone(TransferDone),
        .AccessMem(AccessMem),
        .RWMem(RWMem),
        .SampleData(SampleData),
        .TransferData(TransferData),
        .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    // Expected per-cycle outputs after acceptance, with the TransferDone level
    // to drive on each cycle. d = number of XFER cycles until TransferDone.
    task automatic push_xfer(input int d);
        bit timed_out;
        int n;
        timed_out = 1'b0;
        n = d;
`ifdef TIMEOUT_EN
        if (d > TIMEOUT_CYCLES) begin
            timed_out = 1'b1;
            n = TIMEOUT_CYCLES;
        end
`endif
        for (int j = 0; j < n; j++) begin
            exp_q.push_back(V_TD);
            done_q.push_back(!timed_out && (j == n - 1));
        end
    endtask

    function automatic bit xfer_times_out(input int d);
`ifdef TIMEOUT_EN
        return d > TIMEOUT_CYCLES;
`else
        return 1'b0;
`endif
    endfunction

    task automatic build_trace(input bit rw, input bit mode, input int d);
        exp_q.delete();
        done_q.delete();
        if (!rw) begin
            exp_q.push_back(V_RD_AM); done_q.push_back(1'($urandom));
            exp_q.push_back(V_SD);    done_q.push_back(1'($urandom));
            if (mode) push_xfer(d);
            else begin
                exp_q.push_back(V_TD); done_q.push_back(1'($urandom));
            end
        end else begin
            if (mode) push_xfer(d);
            if (!mode || !xfer_times_out(d)) begin
                exp_q.push_back(V_WR_AM); done_q.push_back(1'($urandom));
            end
        end
    endtask

    // Issue one command in the current idle cycle and follow it to IDLE.
    // abort_at: trace index where Active drops (-1 = none); hold: total cycles
    // ValidCmd stays high counting the accept cycle.
    task automatic run_txn(input string name, input bit rw, input bit mode,
                           input int d, input int abort_at, input int hold);
        build_trace(rw, mode, d);
        if (abort_at >= 0 && abort_at < exp_q.size()) begin
            while (exp_q.size() > abort_at + 1) begin
                void'(exp_q.pop_back());
                void'(done_q.pop_back());
            end
        end
        RW = rw; Mode = mode; ValidCmd = 1'b1; Active = 1'b1;
        TransferDone = 1'($urandom);
        @(negedge Clk);
        check($sformatf("%s_accept", name), outs, V_IDLE);
        @(posedge Clk); #1;
        for (int i = 0; i < exp_q.size(); i++) begin
            ValidCmd = (i + 1 < hold);
            RW = 1'($urandom);
            Mode = 1'($urandom);
            TransferDone = done_q[i];
            Active = (i == abort_at) ? 1'b0 : 1'b1;
            @(negedge Clk);
            check($sformatf("%s[%0d]", name, i), outs, exp_q[i]);
            @(posedge Clk); #1;
        end
        ValidCmd = 1'b0; Active = 1'b1; TransferDone = 1'b0;
    endtask

    task automatic idle_cycles(input string name, input int n, input bit vc);
        for (int i = 0; i < n; i++) begin
            ValidCmd = vc;
            Active = vc ? 1'b0 : 1'($urandom);
            RW = 1'($urandom);
            Mode = 1'($urandom);
            TransferDone = 1'($urandom);
            @(negedge Clk);
            check($sformatf("%s[%0d]", name, i), outs, V_IDLE);
            @(posedge Clk); #1;
        end
        ValidCmd = 1'b0; Active = 1'b1; TransferDone = 1'b0;
    endtask

    initial begin
        // Reset held two cycles, then three quiet cycles.
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("reset_outs", outs, V_IDLE);
        @(posedge Clk); #1;
        Reset = 1'b0;
        idle_cycles("post_reset", 3, 1'b0);

        // Read, handshaked: done after 16 transfer cycles.
        run_txn("rd_m1", 1'b0, 1'b1, 16, -1, 1);
        idle_cycles("rd_m1_idle", 1, 1'b0);

        // Read, single-cycle: later TransferDone is ignored.
        run_txn("rd_m0", 1'b0, 1'b0, 1, -1, 1);
        idle_cycles("rd_m0_idle", 3, 1'b0);

        // Write, handshaked, ValidCmd held 5 cycles: exactly one sequence.
        run_txn("wr_m1_hold", 1'b1, 1'b1, 6, -1, 5);
        idle_cycles("wr_m1_idle", 3, 1'b0);

        // Write, single-cycle.
        run_txn("wr_m0", 1'b1, 1'b0, 1, -1, 1);
        idle_cycles("wr_m0_idle", 1, 1'b0);

        // Active dropped during RD_XFER.
        run_txn("rd_abort", 1'b0, 1'b1, 10, 4, 1);
        idle_cycles("rd_abort_idle", 3, 1'b0);

        // Active dropped during WR_XFER: no memory write afterwards.
        run_txn("wr_abort", 1'b1, 1'b1, 8, 3, 1);
        idle_cycles("wr_abort_idle", 3, 1'b0);

        // Command without Active is ignored.
        idle_cycles("no_active", 4, 1'b1);

        // Back-to-back commands with the minimum one idle cycle.
        run_txn("b2b_a", 1'b1, 1'b0, 1, -1, 1);
        run_txn("b2b_b", 1'b0, 1'b0, 1, -1, 1);

`ifdef TIMEOUT_EN
        // Write with no TransferDone: abort after TIMEOUT_CYCLES, no access.
        run_txn("wr_timeout", 1'b1, 1'b1, 1000, -1, 1);
        idle_cycles("wr_timeout_idle", 3, 1'b0);
        // Done on the very last allowed cycle still completes normally.
        run_txn("wr_done_last", 1'b1, 1'b1, TIMEOUT_CYCLES, -1, 1);
`endif

        // Asynchronous reset in the middle of a read.
        RW = 1'b0; Mode = 1'b1; ValidCmd = 1'b1; Active = 1'b1;
        @(posedge Clk); #1;
        ValidCmd = 1'b0;
        @(negedge Clk);
        check("midrst_pre", outs, V_RD_AM);
        #2 Reset = 1'b1;
        #1 check("midrst_async", outs, V_IDLE);
        @(posedge Clk); #1;
        Reset = 1'b0;
        idle_cycles("midrst_idle", 2, 1'b0);

        // Randomized transactions.
        for (int t = 0; t < 40; t++) begin
            bit rw, mode;
            int d, ab, hold;
            rw   = 1'($urandom);
            mode = 1'($urandom);
            d    = int'($urandom_range(1, 12));
            ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1;
            hold = int'($urandom_range(1, 2));
            run_txn($sformatf("rnd%0d", t), rw, mode, d, ab, hold);
            if ($urandom_range(0, 1) == 1) idle_cycles($sformatf("rnd%0d_idle", t), 1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
